// File: rtl/tpx3_sync_distributor.sv
// Runtime host/client T0_Sync and Reset distributor for Timepix3 readout boards.
// Optional T0 sequence counter is built only when TPX3_SYNC_T0CNT_EN is defined.
module tpx3_sync_distributor #(
   parameter int unsigned N_EXT       = 2,
   parameter int unsigned DELAY_W     = 8,
   parameter int unsigned PULSE_W     = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_mode,
   input  logic                     i_t0_req,
   input  logic                     i_reset_req,
   input  logic [PULSE_W-1:0]       i_pulse_len,
   input  logic [DELAY_W-1:0]       i_local_delay,
   input  logic [N_EXT*DELAY_W-1:0] i_ext_delay,
   input  logic                     i_ext_t0_in,
   input  logic                     i_ext_rst_in,
   output logic                     o_t0_sync,
   output logic                     o_tpx_reset,
   output logic [N_EXT-1:0]         o_ext_t0_out,
   output logic [N_EXT-1:0]         o_ext_rst_out,
   output logic                     o_busy,
   output logic [7:0]               o_drop_count,
   output logic [15:0]              o_t0_count
);
   localparam int unsigned CNT_W = DELAY_W + PULSE_W + 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0]   r_t0_meta, r_rst_meta;
   logic                     r_t0_prev, r_rst_prev, r_t0_rise, r_rst_rise;
   logic                     r_mode, r_kind_rst;
   logic [PULSE_W-1:0]       r_leff;
   logic [DELAY_W-1:0]       r_local_d;
   logic [N_EXT*DELAY_W-1:0] r_ext_d;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_t0_sync, r_tpx_reset, r_busy;
   logic [N_EXT-1:0]         r_ext_t0, r_ext_rst;
   logic [7:0]               r_drop;

   logic [PULSE_W-1:0]       w_leff;
   logic [DELAY_W-1:0]       w_max_d;
   logic [CNT_W-1:0]         w_end;
   logic                     w_idle, w_t0_trig, w_rst_trig, w_trig, w_busy_trig, w_drop_inc;
   logic [N_EXT:0]           w_hit;
   logic                     w_t0_sync_nxt, w_tpx_reset_nxt;
   logic [N_EXT-1:0]         w_ext_t0_nxt, w_ext_rst_nxt;

   function automatic logic in_window(input logic [CNT_W-1:0]   cnt,
                                      input logic [DELAY_W-1:0] d,
                                      input logic [PULSE_W-1:0] len);
      return (cnt >= CNT_W'(d)) && (cnt < (CNT_W'(d) + CNT_W'(len)));
   endfunction

   // Idle uses the live mode; a running sequence judges late triggers by its latched mode.
   assign w_idle      = (r_state == S_IDLE);
   assign w_t0_trig   = i_mode ? r_t0_rise  : i_t0_req;
   assign w_rst_trig  = i_mode ? r_rst_rise : i_reset_req;
   assign w_trig      = w_t0_trig | w_rst_trig;
   assign w_busy_trig = r_mode ? (r_t0_rise | r_rst_rise) : (i_t0_req | i_reset_req);
   assign w_drop_inc  = w_idle ? (w_t0_trig & w_rst_trig) : w_busy_trig;
   assign w_leff      = (i_pulse_len == '0) ? PULSE_W'(1) : i_pulse_len;

   always_comb begin
      w_max_d = r_local_d;
      for (int i = 0; i < int'(N_EXT); i++) begin
         if (r_ext_d[i*DELAY_W +: DELAY_W] > w_max_d) w_max_d = r_ext_d[i*DELAY_W +: DELAY_W];
      end
   end

   assign w_end = CNT_W'(w_max_d) + CNT_W'(r_leff) - CNT_W'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_trig) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == w_end) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_hit = '0;
      if (r_state == S_RUN) begin
         w_hit[0] = in_window(r_cnt, r_local_d, r_leff);
         for (int i = 0; i < int'(N_EXT); i++) begin
            w_hit[i+1] = in_window(r_cnt, r_ext_d[i*DELAY_W +: DELAY_W], r_leff);
         end
      end
      w_t0_sync_nxt   = w_hit[0] & ~r_kind_rst;
      w_tpx_reset_nxt = w_hit[0] &  r_kind_rst;
      w_ext_t0_nxt    = w_hit[N_EXT:1] & {N_EXT{~r_kind_rst}};
      w_ext_rst_nxt   = w_hit[N_EXT:1] & {N_EXT{ r_kind_rst}};
   end

   // Client input synchronisers followed by a registered rising-edge detect.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_t0_meta  <= '0;
         r_rst_meta <= '0;
         r_t0_prev  <= 1'b0;
         r_rst_prev <= 1'b0;
         r_t0_rise  <= 1'b0;
         r_rst_rise <= 1'b0;
      end else begin
         r_t0_meta  <= {r_t0_meta[SYNC_STAGES-2:0], i_ext_t0_in};
         r_rst_meta <= {r_rst_meta[SYNC_STAGES-2:0], i_ext_rst_in};
         r_t0_prev  <= r_t0_meta[SYNC_STAGES-1];
         r_rst_prev <= r_rst_meta[SYNC_STAGES-1];
         r_t0_rise  <= r_t0_meta[SYNC_STAGES-1] & ~r_t0_prev;
         r_rst_rise <= r_rst_meta[SYNC_STAGES-1] & ~r_rst_prev;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode      <= 1'b0;
         r_kind_rst  <= 1'b0;
         r_leff      <= PULSE_W'(1);
         r_local_d   <= '0;
         r_ext_d     <= '0;
         r_cnt       <= '0;
         r_t0_sync   <= 1'b0;
         r_tpx_reset <= 1'b0;
         r_ext_t0    <= '0;
         r_ext_rst   <= '0;
         r_busy      <= 1'b0;
         r_drop      <= '0;
      end else begin
         if (w_idle) begin
            r_mode <= i_mode;
            r_cnt  <= '0;
            if (w_trig) begin
               r_kind_rst <= w_rst_trig;
               r_leff     <= w_leff;
               r_local_d  <= i_local_delay;
               r_ext_d    <= i_ext_delay;
            end
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_t0_sync   <= w_t0_sync_nxt;
         r_tpx_reset <= w_tpx_reset_nxt;
         r_ext_t0    <= w_ext_t0_nxt;
         r_ext_rst   <= w_ext_rst_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         if (w_drop_inc && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end
   end

   assign o_t0_sync     = r_t0_sync;
   assign o_tpx_reset   = r_tpx_reset;
   assign o_ext_t0_out  = r_ext_t0;
   assign o_ext_rst_out = r_ext_rst;
   assign o_busy        = r_busy;
   assign o_drop_count  = r_drop;

`ifdef TPX3_SYNC_T0CNT_EN
   logic [15:0] r_t0_count;

   // Counts T0 sequences as they start; a Reset sequence start clears it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                r_t0_count <= '0;
      else if (w_idle && w_trig) r_t0_count <= w_rst_trig ? 16'd0 : r_t0_count + 16'd1;
   end

   assign o_t0_count = r_t0_count;
`else
   assign o_t0_count = '0;
`endif

endmodule

// File: tb/tb_tpx3_sync_distributor.sv
// Self-checking bench for tpx3_sync_distributor against a cycle-window reference model.
module tb_tpx3_sync_distributor;
   localparam int N_EXT   = 2;
   localparam int DELAY_W = 8;
   localparam int PULSE_W = 4;
   localparam int VW      = 2*N_EXT + 3;

   logic                     i_clk, i_rst, i_mode, i_t0_req, i_reset_req;
   logic [PULSE_W-1:0]       pulse_len;
   logic [DELAY_W-1:0]       local_delay;
   logic [N_EXT*DELAY_W-1:0] ext_delay;
   logic                     i_ext_t0_in, i_ext_rst_in;
   logic                     o_t0_sync, o_tpx_reset, o_busy;
   logic [N_EXT-1:0]         o_ext_t0_out, o_ext_rst_out;
   logic [7:0]               o_drop_count;
   logic [15:0]              o_t0_count;

   tpx3_sync_distributor #(.N_EXT(N_EXT), .DELAY_W(DELAY_W), .PULSE_W(PULSE_W), .SYNC_STAGES(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_t0_req(i_t0_req), .i_reset_req(i_reset_req),
      .i_pulse_len(pulse_len), .i_local_delay(local_delay), .i_ext_delay(ext_delay),
      .i_ext_t0_in(i_ext_t0_in), .i_ext_rst_in(i_ext_rst_in),
      .o_t0_sync(o_t0_sync), .o_tpx_reset(o_tpx_reset), .o_ext_t0_out(o_ext_t0_out),
      .o_ext_rst_out(o_ext_rst_out), .o_busy(o_busy), .o_drop_count(o_drop_count),
      .o_t0_count(o_t0_count));

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a sequence triggered in cycle n keeps BUSY for cycles n+1 .. n+1+maxD+Leff
   // and drives channel c high for cycles n+2+D .. n+1+D+Leff.
   int cur = 0;
   int m_start, m_busy_end, m_leff, m_drop, m_t0cnt;
   bit m_kind_rst;
   int m_d [N_EXT+1];
   bit ev_t0 [8];
   bit ev_rs [8];
   bit prev_et0, prev_ers;

   task automatic model_reset();
      m_start = -1000; m_busy_end = -1000; m_leff = 1; m_drop = 0; m_t0cnt = 0; m_kind_rst = 0;
      for (int c = 0; c <= N_EXT; c++) m_d[c] = 0;
      for (int i = 0; i < 8; i++) begin ev_t0[i] = 0; ev_rs[i] = 0; end
      prev_et0 = 0; prev_ers = 0;
   endtask

   task automatic model_trig(input bit t0, input bit rs);
      int md;
      if (cur > m_busy_end) begin
         if (t0 && rs) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
         if (t0 || rs) begin
            m_start = cur; m_kind_rst = rs;
            m_leff = (pulse_len == 0) ? 1 : int'(pulse_len);
            m_d[0] = int'(local_delay);
            for (int i = 0; i < N_EXT; i++) m_d[i+1] = int'(ext_delay[i*DELAY_W +: DELAY_W]);
            md = 0;
            for (int c = 0; c <= N_EXT; c++) if (m_d[c] > md) md = m_d[c];
            m_busy_end = cur + 1 + md + m_leff;
            m_t0cnt = rs ? 0 : ((m_t0cnt + 1) & 16'hFFFF);
         end
      end else if (t0 || rs) begin
         m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
   endtask

   function automatic logic [VW-1:0] exp_vec(input int k);
      logic [N_EXT:0]   hit;
      logic [N_EXT-1:0] et, er;
      logic             b;
      for (int c = 0; c <= N_EXT; c++)
         hit[c] = (k >= m_start + 2 + m_d[c]) && (k <= m_start + 1 + m_d[c] + m_leff);
      b  = (k >= m_start + 1) && (k <= m_busy_end);
      et = m_kind_rst ? '0 : hit[N_EXT:1];
      er = m_kind_rst ? hit[N_EXT:1] : '0;
      return {hit[0] & ~m_kind_rst, hit[0] & m_kind_rst, et, er, b};
   endfunction

   function automatic logic [15:0] exp_t0cnt();
`ifdef TPX3_SYNC_T0CNT_EN
      return 16'(m_t0cnt);
`else
      return 16'd0;
`endif
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {o_t0_sync, o_tpx_reset, o_ext_t0_out, o_ext_rst_out, o_busy};
   endfunction

   // Drives one cycle of stimulus, advances the model, and stops at the sampling negedge.
   task automatic step(input bit t0, input bit rs, input bit et0, input bit ers);
      i_t0_req = t0; i_reset_req = rs; i_ext_t0_in = et0; i_ext_rst_in = ers;
      if (et0 && !prev_et0) ev_t0[(cur + 3) % 8] = 1;
      if (ers && !prev_ers) ev_rs[(cur + 3) % 8] = 1;
      prev_et0 = et0; prev_ers = ers;
      if (!i_mode) model_trig(t0, rs);
      else         model_trig(ev_t0[cur % 8], ev_rs[cur % 8]);
      ev_t0[cur % 8] = 0; ev_rs[cur % 8] = 0;
      @(negedge i_clk);
   endtask

   task automatic next();
      @(posedge i_clk); #1; cur++;
   endtask

   task automatic do_reset();
      @(posedge i_clk); #1;
      i_rst = 1; i_t0_req = 0; i_reset_req = 0; i_ext_t0_in = 0; i_ext_rst_in = 0;
      #20;
      @(posedge i_clk); #1;
      i_rst = 0; cur += 10;
      model_reset();
   endtask

   task automatic rand_cfg();
      pulse_len   = PULSE_W'($urandom_range(0, 6));
      local_delay = DELAY_W'($urandom_range(0, 10));
      for (int i = 0; i < N_EXT; i++) ext_delay[i*DELAY_W +: DELAY_W] = DELAY_W'($urandom_range(0, 10));
   endtask

   task automatic test_reset();
      @(posedge i_clk); #1; i_rst = 1; #3;
      n_tests++;
      if ({dut_vec(), o_drop_count, o_t0_count} !== '0)
         $display("FAIL reset_state got=%b required=0", {dut_vec(), o_drop_count, o_t0_count});
      do_reset();
      n_tests++;
      if (dut_vec() !== exp_vec(cur)) $display("FAIL reset_release got=%b required=%b", dut_vec(), exp_vec(cur));
      if (dut_vec() !== exp_vec(cur)) n_fail++;
   endtask

   task automatic test_spec_example();
      int busy_n, t0_n, e0_first, e1_first, req_c;
      i_mode = 0; do_reset();
      pulse_len = 4'd3; local_delay = 8'd0; ext_delay = {8'd5, 8'd2};
      busy_n = 0; t0_n = 0; e0_first = -1; e1_first = -1; req_c = cur;
      for (int k = 0; k < 14; k++) begin
         step(k == 0, 0, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL spec_example cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         if (o_busy) busy_n++;
         if (o_t0_sync) t0_n++;
         if (o_ext_t0_out[0] && e0_first < 0) e0_first = cur - req_c;
         if (o_ext_t0_out[1] && e1_first < 0) e1_first = cur - req_c;
         next();
      end
      n_tests++; if (busy_n !== 9) begin n_fail++; $display("FAIL busy_cycles got=%0d required=9", busy_n); end
      n_tests++; if (t0_n !== 3) begin n_fail++; $display("FAIL t0_sync_cycles got=%0d required=3", t0_n); end
      n_tests++; if (e0_first !== 4) begin n_fail++; $display("FAIL ext0_start got=%0d required=4", e0_first); end
      n_tests++; if (e1_first !== 7) begin n_fail++; $display("FAIL ext1_start got=%0d required=7", e1_first); end
   endtask

   task automatic test_simultaneous();
      int rst_n;
      i_mode = 0; do_reset();
      pulse_len = 4'd2; local_delay = 8'd1; ext_delay = {8'd3, 8'd0};
      rst_n = 0;
      for (int k = 0; k < 12; k++) begin
         step(k == 0, k == 0, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL simultaneous cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         if (o_tpx_reset) rst_n++;
         next();
      end
      n_tests++; if (rst_n !== 2) begin n_fail++; $display("FAIL simul_reset_cycles got=%0d required=2", rst_n); end
      n_tests++; if (o_drop_count !== 8'd1) begin n_fail++; $display("FAIL simul_drop got=%0d required=1", o_drop_count); end
   endtask

   task automatic test_saturate();
      i_mode = 0; do_reset();
      pulse_len = 4'd0; local_delay = 8'd0; ext_delay = '0;
      for (int k = 0; k < 503; k++) begin
         step(k < 500, 0, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL saturate cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         next();
      end
      n_tests++; if (o_drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_saturate got=%0d required=255", o_drop_count); end
   endtask

   task automatic test_client();
      int rises, first, j0;
      logic last;
      i_mode = 1; do_reset();
      pulse_len = 4'd2; local_delay = 8'd0; ext_delay = '0;
      rises = 0; first = -1; j0 = 0; last = 0;
      for (int k = 0; k < 70; k++) begin
         if (k == 3) j0 = cur;
         step($urandom_range(0, 3) == 0, 0, (k >= 3 && k < 53), 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL client_level cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         if (o_t0_sync && !last) begin rises++; if (first < 0) first = cur; end
         last = o_t0_sync;
         next();
      end
      n_tests++; if (rises !== 1) begin n_fail++; $display("FAIL client_one_seq got=%0d required=1", rises); end
      n_tests++; if (first !== j0 + 5) begin n_fail++; $display("FAIL client_latency got=%0d required=%0d", first - j0, 5); end
      n_tests++; if (o_drop_count !== 8'd0) begin n_fail++; $display("FAIL client_ignore_req got=%0d required=0", o_drop_count); end
   endtask

   task automatic test_random_host();
      i_mode = 0; do_reset(); rand_cfg();
      for (int k = 0; k < 1540; k++) begin
         if ($urandom_range(0, 3) == 0) rand_cfg();
         step(k < 1500 && $urandom_range(0, 9) == 0, k < 1500 && $urandom_range(0, 19) == 0, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL random_host cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         next();
      end
      n_tests++; if (o_drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL host_drop got=%0d required=%0d", o_drop_count, m_drop); end
      n_tests++; if (o_t0_count !== exp_t0cnt()) begin n_fail++; $display("FAIL host_t0cnt got=%0d required=%0d", o_t0_count, exp_t0cnt()); end
   endtask

   task automatic test_random_client();
      bit et0, ers;
      i_mode = 1; do_reset(); rand_cfg();
      et0 = 0; ers = 0;
      for (int k = 0; k < 1540; k++) begin
         if ($urandom_range(0, 3) == 0) rand_cfg();
         if (k < 1500 && $urandom_range(0, 4) == 0) et0 = ~et0;
         if (k < 1500 && $urandom_range(0, 11) == 0) ers = ~ers;
         step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, et0, ers);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL random_client cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         next();
      end
      n_tests++; if (o_drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL client_drop got=%0d required=%0d", o_drop_count, m_drop); end
      n_tests++; if (o_t0_count !== exp_t0cnt()) begin n_fail++; $display("FAIL client_t0cnt got=%0d required=%0d", o_t0_count, exp_t0cnt()); end
   endtask

   task automatic test_rst_mid();
      i_mode = 0; do_reset();
      pulse_len = 4'd15; local_delay = 8'd30; ext_delay = {8'd40, 8'd1};
      for (int k = 0; k < 5; k++) begin
         step(k == 0, 0, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL rst_mid_pre cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         next();
      end
      n_tests++; if (o_ext_t0_out[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_active got=%b required=1", o_ext_t0_out[0]); end
      #2; i_rst = 1; #1;
      n_tests++;
      if ({dut_vec(), o_drop_count} !== '0) begin
         n_fail++; $display("FAIL rst_mid_async got=%b required=0", {dut_vec(), o_drop_count});
      end
      @(posedge i_clk); #1; i_rst = 0; cur += 10; model_reset();
      for (int k = 0; k < 20; k++) begin
         step(k == 0, 0, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL rst_mid_after cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         next();
      end
   endtask

   task automatic test_t0count();
      logic [15:0] req3;
`ifdef TPX3_SYNC_T0CNT_EN
      req3 = 16'd3;
`else
      req3 = 16'd0;
`endif
      i_mode = 0; do_reset();
      pulse_len = 4'd1; local_delay = 8'd0; ext_delay = '0;
      for (int k = 0; k < 20; k++) begin
         step((k % 5) == 0 && k < 15, k == 15, 0, 0);
         n_tests++;
         if (dut_vec() !== exp_vec(cur)) begin
            n_fail++; $display("FAIL t0count_seq cyc=%0d got=%b required=%b", k, dut_vec(), exp_vec(cur));
         end
         if (k == 14) begin
            n_tests++; if (o_t0_count !== req3) begin n_fail++; $display("FAIL t0count_three got=%0d required=%0d", o_t0_count, req3); end
         end
         next();
      end
      n_tests++; if (o_t0_count !== 16'd0) begin n_fail++; $display("FAIL t0count_cleared got=%0d required=0", o_t0_count); end
   endtask

   initial begin
      i_rst = 1; i_mode = 0; i_t0_req = 0; i_reset_req = 0; i_ext_t0_in = 0; i_ext_rst_in = 0;
      pulse_len = '0; local_delay = '0; ext_delay = '0;
      model_reset();
      test_reset();
      test_spec_example();
      test_simultaneous();
      test_saturate();
      test_client();
      test_rst_mid();
      test_t0count();
      test_random_host();
      test_random_client();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end
endmodule
